// File: rtl/pic_bus_pkg.sv
// pic_bus_pkg
//   Shared types and constants for the 8259A PIC bus initiator.
//   - state_e      : bus phase sequencer states
//   - icw_e        : which ICW word the init sequencer is issuing
//   - ICW1_*       : bit positions inside ICW1 that shape the init sequence
//   - DEF_*_CYCLES : default phase lengths of a bus transaction
//   - next_icw()   : picks the ICW that follows the current one
package pic_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ICW_1 = 2'd0,
        ICW_2 = 2'd1,
        ICW_3 = 2'd2,
        ICW_4 = 2'd3
    } icw_e;

    typedef struct packed {
        logic more;
        icw_e step;
    } icw_next_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;

    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES  = 1;

    // ICW3 only exists in cascade mode (SNGL=0); ICW4 only when IC4=1.
    function automatic icw_next_t next_icw(input icw_e cur, input logic [7:0] icw1);
        icw_next_t r;
        r.more = 1'b0;
        r.step = cur;
        case (cur)
            ICW_1: begin
                r.more = 1'b1;
                r.step = ICW_2;
            end
            ICW_2: begin
                if (!icw1[ICW1_SNGL]) begin
                    r.more = 1'b1;
                    r.step = ICW_3;
                end else if (icw1[ICW1_IC4]) begin
                    r.more = 1'b1;
                    r.step = ICW_4;
                end
            end
            ICW_3: begin
                if (icw1[ICW1_IC4]) begin
                    r.more = 1'b1;
                    r.step = ICW_4;
                end
            end
            default: begin
                r.more = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pic_bus_phase_timer.sv
// pic_bus_phase_timer
//   Loadable down-counter shared by every bus phase. Loading N-1 makes the
//   terminal-count flag rise in the Nth cycle of the phase.
//   Ports:
//     clk        : system clock
//     rst_n      : asynchronous active-low reset
//     load_i     : load load_val_i this cycle
//     load_val_i : phase length minus one
//     tc_o       : counter has reached zero (last cycle of the phase)
module pic_bus_phase_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    // Count down to zero and park there until the next phase reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/pic_bus_initiator.sv
// pic_bus_initiator
//   Turns single-cycle host requests into timed CS/WR/RD/A0 sequences on the
//   8-bit 8259A bus, and runs the ICW1..ICW4 initialization sequence on its own.
//   Ports:
//     clk, rst_n              : clock, asynchronous active-low reset
//     init_start, init_icw1-4 : start the ICW sequence with these values
//     init_busy, init_done    : sequence in progress / one-cycle completion pulse
//     cmd_valid/ready/rd/a0/data : host request handshake and payload
//     rd_data, rd_valid       : captured read data and its one-cycle strobe
//     cs_n, wr_n, rd_n, a0    : registered PIC bus control
//     dbus_out, dbus_oe       : data toward the PIC and its output enable
//     dbus_in                 : data returned by the PIC
module pic_bus_initiator
    import pic_bus_pkg::*;
#(
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_start,
    input  logic [7:0] init_icw1,
    input  logic [7:0] init_icw2,
    input  logic [7:0] init_icw3,
    input  logic [7:0] init_icw4,
    output logic       init_busy,
    output logic       init_done,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a0,
    output logic [7:0] dbus_out,
    output logic       dbus_oe,
    input  logic [7:0] dbus_in
);

    localparam int MAXP = (SETUP_CYCLES > PULSE_CYCLES)
                        ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                        : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
    localparam int CW = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic       txn_rd_q, txn_rd_d;
    logic       txn_a0_q, txn_a0_d;
    logic [7:0] txn_data_q, txn_data_d;
    logic [7:0] icw1_q, icw1_d;
    logic [7:0] icw2_q, icw2_d;
    logic [7:0] icw3_q, icw3_d;
    logic [7:0] icw4_q, icw4_d;
    icw_e       step_q, step_d;
    logic       init_busy_q, init_busy_d;
    logic       init_done_q, init_done_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;

    logic       cs_n_q, cs_n_d;
    logic       wr_n_q, wr_n_d;
    logic       rd_n_q, rd_n_d;
    logic       a0_q, a0_d;
    logic [7:0] dbus_out_q, dbus_out_d;
    logic       dbus_oe_q, dbus_oe_d;

    logic          tmr_load;
    logic [CW-1:0] tmr_load_val;
    logic          tmr_tc;
    icw_next_t     nxt;
    logic [7:0]    nxt_data;
    logic          accept_init;
    logic          accept_cmd;
    logic          bus_active;

    pic_bus_phase_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .tc_o       (tmr_tc)
    );

    // init_start has priority over a host command arriving in the same cycle.
    assign cmd_ready   = (state_q == ST_IDLE) && !init_busy_q && !init_start;
    assign accept_init = init_start && (state_q == ST_IDLE) && !init_busy_q;
    assign accept_cmd  = cmd_valid && cmd_ready;

    // State, transaction latches and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            txn_rd_q    <= 1'b0;
            txn_a0_q    <= 1'b0;
            txn_data_q  <= 8'h00;
            icw1_q      <= 8'h00;
            icw2_q      <= 8'h00;
            icw3_q      <= 8'h00;
            icw4_q      <= 8'h00;
            step_q      <= ICW_1;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 8'h00;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            a0_q        <= 1'b0;
            dbus_out_q  <= 8'h00;
            dbus_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            txn_rd_q    <= txn_rd_d;
            txn_a0_q    <= txn_a0_d;
            txn_data_q  <= txn_data_d;
            icw1_q      <= icw1_d;
            icw2_q      <= icw2_d;
            icw3_q      <= icw3_d;
            icw4_q      <= icw4_d;
            step_q      <= step_d;
            init_busy_q <= init_busy_d;
            init_done_q <= init_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            a0_q        <= a0_d;
            dbus_out_q  <= dbus_out_d;
            dbus_oe_q   <= dbus_oe_d;
        end
    end

    // Phase sequencing, request acceptance and ICW stepping.
    always_comb begin
        state_d      = state_q;
        txn_rd_d     = txn_rd_q;
        txn_a0_d     = txn_a0_q;
        txn_data_d   = txn_data_q;
        icw1_d       = icw1_q;
        icw2_d       = icw2_q;
        icw3_d       = icw3_q;
        icw4_d       = icw4_q;
        step_d       = step_q;
        init_busy_d  = init_busy_q;
        init_done_d  = 1'b0;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        tmr_load     = 1'b0;
        tmr_load_val = SETUP_LD;
        nxt          = next_icw(step_q, icw1_q);
        case (nxt.step)
            ICW_2:   nxt_data = icw2_q;
            ICW_3:   nxt_data = icw3_q;
            default: nxt_data = icw4_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (accept_init) begin
                    state_d      = ST_SETUP;
                    tmr_load     = 1'b1;
                    tmr_load_val = SETUP_LD;
                    icw1_d       = init_icw1;
                    icw2_d       = init_icw2;
                    icw3_d       = init_icw3;
                    icw4_d       = init_icw4;
                    step_d       = ICW_1;
                    init_busy_d  = 1'b1;
                    txn_rd_d     = 1'b0;
                    txn_a0_d     = 1'b0;
                    txn_data_d   = init_icw1;
                end else if (accept_cmd) begin
                    state_d      = ST_SETUP;
                    tmr_load     = 1'b1;
                    tmr_load_val = SETUP_LD;
                    txn_rd_d     = cmd_rd;
                    txn_a0_d     = cmd_a0;
                    txn_data_d   = cmd_data;
                end
            end
            ST_SETUP: begin
                if (tmr_tc) begin
                    state_d      = ST_STROBE;
                    tmr_load     = 1'b1;
                    tmr_load_val = PULSE_LD;
                end
            end
            ST_STROBE: begin
                // The edge that ends the strobe is where read data is sampled.
                if (tmr_tc) begin
                    state_d      = ST_HOLD;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LD;
                    if (txn_rd_q) begin
                        rd_data_d  = dbus_in;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_tc) begin
                    if (init_busy_q && nxt.more) begin
                        state_d    = ST_GAP;
                        step_d     = nxt.step;
                        txn_a0_d   = 1'b1;
                        txn_data_d = nxt_data;
                    end else begin
                        state_d = ST_IDLE;
                        if (init_busy_q) begin
                            init_busy_d = 1'b0;
                            init_done_d = 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                state_d      = ST_SETUP;
                tmr_load     = 1'b1;
                tmr_load_val = SETUP_LD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are derived from the upcoming state so that, once registered,
    // they line up exactly with the phase they belong to.
    always_comb begin
        bus_active = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_n_d     = !bus_active;
        wr_n_d     = !((state_d == ST_STROBE) && !txn_rd_d);
        rd_n_d     = !((state_d == ST_STROBE) && txn_rd_d);
        a0_d       = bus_active ? txn_a0_d : 1'b0;
        dbus_oe_d  = bus_active && !txn_rd_d;
        dbus_out_d = (bus_active && !txn_rd_d) ? txn_data_d : 8'h00;
    end

    assign init_busy = init_busy_q;
    assign init_done = init_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign cs_n      = cs_n_q;
    assign wr_n      = wr_n_q;
    assign rd_n      = rd_n_q;
    assign a0        = a0_q;
    assign dbus_out  = dbus_out_q;
    assign dbus_oe   = dbus_oe_q;

endmodule

// File: tb/tb_pic_bus_initiator.sv
// tb_pic_bus_initiator
//   Directed bench for pic_bus_initiator. A cycle-indexed expectation table is
//   filled from the bus protocol rules whenever a request is issued; a compare
//   process checks every cycle against it, and literal checks pin the table.
module tb_pic_bus_initiator;

    localparam int S    = 1;
    localparam int P    = 2;
    localparam int H    = 1;
    localparam int MAXC = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_start = 1'b0;
    logic [7:0] init_icw1 = 8'h00;
    logic [7:0] init_icw2 = 8'h00;
    logic [7:0] init_icw3 = 8'h00;
    logic [7:0] init_icw4 = 8'h00;
    logic       init_busy;
    logic       init_done;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rd = 1'b0;
    logic       cmd_a0 = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] dbus_out;
    logic       dbus_oe;
    logic [7:0] dbus_in = 8'hEE;

    pic_bus_initiator #(
        .SETUP_CYCLES (S),
        .PULSE_CYCLES (P),
        .HOLD_CYCLES  (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_start (init_start),
        .init_icw1  (init_icw1),
        .init_icw2  (init_icw2),
        .init_icw3  (init_icw3),
        .init_icw4  (init_icw4),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rd     (cmd_rd),
        .cmd_a0     (cmd_a0),
        .cmd_data   (cmd_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .cs_n       (cs_n),
        .wr_n       (wr_n),
        .rd_n       (rd_n),
        .a0         (a0),
        .dbus_out   (dbus_out),
        .dbus_oe    (dbus_oe),
        .dbus_in    (dbus_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Expected behaviour per cycle index.
    bit       expCs[MAXC];
    bit       expWr[MAXC];
    bit       expRdn[MAXC];
    bit       expA0[MAXC];
    bit       expOe[MAXC];
    bit       expOutChk[MAXC];
    bit [7:0] expOut[MAXC];
    bit       expBusy[MAXC];
    bit       expDone[MAXC];
    bit       expRv[MAXC];
    bit [7:0] expRdData[MAXC];
    bit       expIdle[MAXC];
    bit [7:0] expDin[MAXC];

    int total = 0;
    int bad   = 0;
    int nextFree = 0;

    int       csLow, wrLow, rdLow, rvCnt, doneCnt;
    bit       wrPrev = 1'b1;
    bit [8:0] writes[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void clearModel(input int from);
        for (int c = from; c < MAXC; c++) begin
            expCs[c] = 1'b1;  expWr[c] = 1'b1;  expRdn[c] = 1'b1;
            expA0[c] = 1'b0;  expOe[c] = 1'b0;  expOutChk[c] = 1'b1;
            expOut[c] = 8'h00; expBusy[c] = 1'b0; expDone[c] = 1'b0;
            expRv[c] = 1'b0;  expRdData[c] = 8'h00; expIdle[c] = 1'b1;
            expDin[c] = 8'hEE;
        end
    endfunction

    // One bus transaction starting at cycle s; returns the first free cycle after it.
    function automatic int schedTxn(input int s, input bit rd, input bit a0v,
                                    input bit [7:0] d, input bit [7:0] din);
        for (int i = 0; i < S + P + H; i++) begin
            int c = s + i;
            if (c < MAXC) begin
                expIdle[c]   = 1'b0;
                expCs[c]     = 1'b0;
                expA0[c]     = a0v;
                expOe[c]     = !rd;
                expOutChk[c] = !rd;
                expOut[c]    = rd ? 8'h00 : d;
                if (i >= S && i < S + P) begin
                    if (rd) begin
                        expRdn[c] = 1'b0;
                        expDin[c] = din;
                    end else begin
                        expWr[c] = 1'b0;
                    end
                end
            end
        end
        if (rd && (s + S + P) < MAXC) begin
            expRv[s + S + P]     = 1'b1;
            expRdData[s + S + P] = din;
        end
        return s + S + P + H;
    endfunction

    // ICW list from ICW1 flags, one idle gap between writes, done after the last.
    function automatic int schedInit(input int s, input bit [7:0] i1, input bit [7:0] i2,
                                     input bit [7:0] i3, input bit [7:0] i4);
        bit [8:0] seq[$];
        int c;
        seq.push_back({1'b0, i1});
        seq.push_back({1'b1, i2});
        if (!i1[1]) seq.push_back({1'b1, i3});
        if (i1[0])  seq.push_back({1'b1, i4});
        c = s;
        foreach (seq[k]) begin
            if (k > 0) begin
                expIdle[c] = 1'b0;
                c++;
            end
            c = schedTxn(c, 1'b0, seq[k][8], seq[k][7:0], 8'hEE);
        end
        for (int j = s; j < c; j++) expBusy[j] = 1'b1;
        expDone[c] = 1'b1;
        return c;
    endfunction

    // Drives one request cycle; called just after a rising edge.
    task automatic applyStimulus(input bit doInit, input bit doCmd, input bit rd, input bit a0v,
                                 input bit [7:0] d, input bit [7:0] din,
                                 input bit [7:0] i1, input bit [7:0] i2,
                                 input bit [7:0] i3, input bit [7:0] i4);
        int c = cyc;
        init_start = doInit;
        cmd_valid  = doCmd;
        cmd_rd     = rd;
        cmd_a0     = a0v;
        cmd_data   = d;
        init_icw1  = i1;
        init_icw2  = i2;
        init_icw3  = i3;
        init_icw4  = i4;
        if (c + 1 < MAXC && expIdle[c] && !expBusy[c]) begin
            if (doInit)     nextFree = schedInit(c + 1, i1, i2, i3, i4);
            else if (doCmd) nextFree = schedTxn(c + 1, rd, a0v, d, din);
        end
        @(posedge clk); #1;
        init_start = 1'b0;
        cmd_valid  = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitFree();
        int guard = 0;
        while (cyc < nextFree && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic clearMon();
        csLow = 0; wrLow = 0; rdLow = 0; rvCnt = 0; doneCnt = 0;
        writes.delete();
    endtask

    // PIC side: drive read data only while the model expects the read strobe.
    initial begin
        forever begin
            @(posedge clk); #1;
            dbus_in = (cyc < MAXC) ? expDin[cyc] : 8'hEE;
        end
    end

    // Bus monitor for the literal checks.
    always @(negedge clk) begin
        if (!cs_n) csLow++;
        if (!wr_n) wrLow++;
        if (!rd_n) rdLow++;
        if (rd_valid) rvCnt++;
        if (init_done) doneCnt++;
        if (!wr_n && wrPrev) writes.push_back({a0, dbus_out});
        wrPrev = wr_n;
    end

    // Per-cycle comparison against the expectation table.
    always @(negedge clk) begin
        if (cyc > 0 && cyc < MAXC) begin
            logic [24:0] act;
            logic [24:0] exp;
            act = {cs_n, wr_n, rd_n, a0, dbus_oe,
                   (expOutChk[cyc] ? dbus_out : 8'h00),
                   init_busy, init_done, rd_valid, cmd_ready,
                   (expRv[cyc] ? rd_data : 8'h00)};
            exp = {expCs[cyc], expWr[cyc], expRdn[cyc], expA0[cyc], expOe[cyc],
                   expOut[cyc],
                   expBusy[cyc], expDone[cyc], expRv[cyc],
                   (expIdle[cyc] && !expBusy[cyc] && !init_start),
                   expRdData[cyc]};
            checkOutput($sformatf("cyc%0d bus{cs,wr,rd,a0,oe,out,busy,done,rv,rdy,rdata}", cyc),
                        32'(act), 32'(exp));
        end
    end

    initial begin
        #300000;
        bad++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, wanted finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        clearModel(0);
        clearMon();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Quiet bus after reset.
        waitCycles(5);
        checkOutput("reset cs_n", 32'(cs_n), 32'd1);
        checkOutput("reset wr_n/rd_n", 32'({wr_n, rd_n}), 32'h3);
        checkOutput("reset dbus_oe", 32'(dbus_oe), 32'd0);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset rd_data", 32'(rd_data), 32'h00);

        // Write 0xFB at a0=1.
        clearMon();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        waitFree(); waitCycles(1);
        checkOutput("write cs low cycles", 32'(csLow), 32'd4);
        checkOutput("write wr low cycles", 32'(wrLow), 32'd2);
        checkOutput("write count", 32'(writes.size()), 32'd1);
        checkOutput("write a0/data", 32'((writes.size() > 0) ? writes[0] : 9'h000), 32'h1FB);

        // Read at a0=0, PIC returns 0x5A.
        clearMon();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00);
        waitFree(); waitCycles(1);
        checkOutput("read rd low cycles", 32'(rdLow), 32'd2);
        checkOutput("read rd_valid pulses", 32'(rvCnt), 32'd1);
        checkOutput("read rd_data", 32'(rd_data), 32'h5A);
        checkOutput("read no wr strobe", 32'(wrLow), 32'd0);

        // Back-to-back: write then read issued on the first free cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        waitFree();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00);
        waitFree(); waitCycles(1);
        checkOutput("b2b rd_data", 32'(rd_data), 32'h3C);

        // Init 0x13: ICW1, ICW2, ICW4; retriggers and commands during it are ignored.
        clearMon();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h13, 8'h20, 8'hAA, 8'h01);
        waitCycles(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h99, 8'h00, 8'h11, 8'h55, 8'h66, 8'h77);
        waitFree(); waitCycles(2);
        checkOutput("init13 writes", 32'(writes.size()), 32'd3);
        checkOutput("init13 w0", 32'((writes.size() > 0) ? writes[0] : 9'h000), 32'h013);
        checkOutput("init13 w1", 32'((writes.size() > 1) ? writes[1] : 9'h000), 32'h120);
        checkOutput("init13 w2", 32'((writes.size() > 2) ? writes[2] : 9'h000), 32'h101);
        checkOutput("init13 done pulses", 32'(doneCnt), 32'd1);

        // Init 0x11: all four ICWs.
        clearMon();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44);
        waitFree(); waitCycles(2);
        checkOutput("init11 writes", 32'(writes.size()), 32'd4);
        checkOutput("init11 w2", 32'((writes.size() > 2) ? writes[2] : 9'h000), 32'h133);
        checkOutput("init11 w3", 32'((writes.size() > 3) ? writes[3] : 9'h000), 32'h144);

        // Init 0x12 together with a command: init wins, two writes only.
        clearMon();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78);
        waitFree(); waitCycles(2);
        checkOutput("init12 writes", 32'(writes.size()), 32'd2);
        checkOutput("init12 w0", 32'((writes.size() > 0) ? writes[0] : 9'h000), 32'h012);
        checkOutput("init12 w1", 32'((writes.size() > 1) ? writes[1] : 9'h000), 32'h134);
        checkOutput("init12 wr low cycles", 32'(wrLow), 32'd4);

        // Init 0x10: cascade, no ICW4.
        clearMon();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h10, 8'h08, 8'h04, 8'hFF);
        waitFree(); waitCycles(2);
        checkOutput("init10 writes", 32'(writes.size()), 32'd3);
        checkOutput("init10 w2", 32'((writes.size() > 2) ? writes[2] : 9'h000), 32'h104);

        // Reset in the middle of the ICW2 strobe.
        clearMon();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h13, 8'h20, 8'h00, 8'h01);
        waitCycles(6);
        #2 rst_n = 1'b0;
        clearModel(cyc);
        #1;
        checkOutput("async reset wr_n/cs_n", 32'({wr_n, cs_n}), 32'h3);
        checkOutput("async reset init_busy", 32'(init_busy), 32'd0);
        checkOutput("async reset rd_data", 32'(rd_data), 32'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        waitCycles(20);
        checkOutput("post-reset done pulses", 32'(doneCnt), 32'd0);
        checkOutput("post-reset writes", 32'(writes.size()), 32'd1);

        // Bus usable again after the abandoned sequence.
        clearMon();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        waitFree(); waitCycles(1);
        checkOutput("post-reset write", 32'((writes.size() > 0) ? writes[0] : 9'h000), 32'h1C3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
